// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the posted-write store buffer.
package store_buffer_pkg;

  localparam int unsigned AddrWidth     = 32;
  localparam int unsigned DataWidth     = 32;
  localparam int unsigned SelWidth      = 4;
  localparam int unsigned WordAddrWidth = 30;

  // One buffered store: word address, byte-lane enables and data.
  typedef struct packed {
    logic [WordAddrWidth-1:0] addr;
    logic [SelWidth-1:0]      sel;
    logic [DataWidth-1:0]     data;
  } sb_entry_t;

  // Word index of a byte address; the lane offset is carried by sel instead.
  function automatic logic [WordAddrWidth-1:0] word_index(input logic [AddrWidth-1:0] byte_addr);
    return byte_addr[AddrWidth-1:2];
  endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// Entry storage for the store buffer: circular FIFO with head/tail pointers and occupancy count.
// All entries are exposed so the parent can forward bytes from any valid slot.
module store_buffer_fifo
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PTR_WIDTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push_i,
  input  sb_entry_t            push_entry_i,
  input  logic                 pop_i,
  output sb_entry_t            entries_o [DEPTH],
  output logic [PTR_WIDTH-1:0] head_o,
  output logic [PTR_WIDTH:0]   count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam logic [PTR_WIDTH-1:0] PtrOne     = {{(PTR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PTR_WIDTH:0]   CountOne   = {{PTR_WIDTH{1'b0}}, 1'b1};
  localparam logic [PTR_WIDTH:0]   DepthCount = {1'b1, {PTR_WIDTH{1'b0}}};

  sb_entry_t            mem_q [DEPTH];
  sb_entry_t            mem_d [DEPTH];
  logic [PTR_WIDTH-1:0] head_q, head_d;
  logic [PTR_WIDTH-1:0] tail_q, tail_d;
  logic [PTR_WIDTH:0]   count_q, count_d;

  // Next-state: pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_i) begin
      mem_d[tail_q] = push_entry_i;
      tail_d        = tail_q + PtrOne;
    end
    if (pop_i) begin
      head_d = head_q + PtrOne;
    end
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CountOne;
      2'b01:   count_d = count_q - CountOne;
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payloads are never cleared; count alone decides validity.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  // Status outputs.
  always_comb begin
    entries_o = mem_q;
    head_o    = head_q;
    count_o   = count_q;
    full_o    = (count_q == DepthCount);
    empty_o   = (count_q == '0);
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the CPU data port and a single-ported data RAM.
// Stores queue in a FIFO and drain on cycles without a CPU load; loads see buffered
// stores through byte-wise forwarding from the youngest matching entry.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PTR_WIDTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_write_enable,
  input  logic [31:0] cpu_write_address,
  input  logic [3:0]  cpu_write_select,
  input  logic [31:0] cpu_write_data,
  input  logic        cpu_read_enable,
  input  logic [31:0] cpu_read_address,
  output logic [31:0] cpu_read_data,
  output logic        stall_request,
  output logic        empty,
  output logic        ram_read_enable,
  output logic [31:0] ram_read_address,
  input  logic [31:0] ram_read_data,
  output logic        ram_write_enable,
  output logic [31:0] ram_write_address,
  output logic [3:0]  ram_write_select,
  output logic [31:0] ram_write_data
);

  sb_entry_t            entries [DEPTH];
  sb_entry_t            push_entry;
  sb_entry_t            head_entry;
  logic [PTR_WIDTH-1:0] fifo_head;
  logic [PTR_WIDTH:0]   fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 drain;
  logic                 push;

  store_buffer_fifo #(
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (drain),
    .entries_o    (entries),
    .head_o       (fifo_head),
    .count_o      (fifo_count),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  // Drain/enqueue arbitration: CPU loads own the RAM port, reset suppresses both.
  always_comb begin
    drain         = ~reset & ~fifo_empty & ~cpu_read_enable;
    // A full buffer still accepts when the head leaves in the same cycle.
    push          = ~reset & cpu_write_enable & (~fifo_full | drain);
    stall_request = cpu_write_enable & fifo_full & ~drain;
    empty         = fifo_empty;
    push_entry    = '{addr: word_index(cpu_write_address),
                      sel:  cpu_write_select,
                      data: cpu_write_data};
  end

  // RAM port: reads pass straight through, writes come from the FIFO head.
  always_comb begin
    head_entry        = entries[fifo_head];
    ram_read_enable   = cpu_read_enable;
    ram_read_address  = cpu_read_address;
    ram_write_enable  = drain;
    ram_write_address = {head_entry.addr, 2'b00};
    ram_write_select  = head_entry.sel;
    ram_write_data    = head_entry.data;
  end

  // Forwarding: walk oldest to youngest so later matches overwrite earlier lanes.
  always_comb begin
    logic [PTR_WIDTH-1:0] idx;
    cpu_read_data = ram_read_data;
    idx           = fifo_head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = fifo_head + k[PTR_WIDTH-1:0];
      if ((k < int'(fifo_count)) && (entries[idx].addr == word_index(cpu_read_address))) begin
        for (int lane = 0; lane < 4; lane++) begin
          if (entries[idx].sel[lane]) begin
            cpu_read_data[8*lane +: 8] = entries[idx].data[8*lane +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_write_enable;
  logic [31:0] cpu_write_address;
  logic [3:0]  cpu_write_select;
  logic [31:0] cpu_write_data;
  logic        cpu_read_enable;
  logic [31:0] cpu_read_address;
  logic [31:0] cpu_read_data;
  logic        stall_request;
  logic        empty;
  logic        ram_read_enable;
  logic [31:0] ram_read_address;
  logic [31:0] ram_read_data;
  logic        ram_write_enable;
  logic [31:0] ram_write_address;
  logic [3:0]  ram_write_select;
  logic [31:0] ram_write_data;

  always #5 clock = ~clock;

  store_buffer #(
    .DEPTH     (4),
    .PTR_WIDTH (2)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .cpu_write_enable  (cpu_write_enable),
    .cpu_write_address (cpu_write_address),
    .cpu_write_select  (cpu_write_select),
    .cpu_write_data    (cpu_write_data),
    .cpu_read_enable   (cpu_read_enable),
    .cpu_read_address  (cpu_read_address),
    .cpu_read_data     (cpu_read_data),
    .stall_request     (stall_request),
    .empty             (empty),
    .ram_read_enable   (ram_read_enable),
    .ram_read_address  (ram_read_address),
    .ram_read_data     (ram_read_data),
    .ram_write_enable  (ram_write_enable),
    .ram_write_address (ram_write_address),
    .ram_write_select  (ram_write_select),
    .ram_write_data    (ram_write_data)
  );

  // Reference model: the buffer is just an ordered list of pending stores.
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
  } mentry_t;

  mentry_t mq[$];
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [31:0] wa;
    logic [3:0]  ws;
    logic [31:0] wd;
    logic        re;
    logic [31:0] ra;
    logic [31:0] rd;
    logic        e_stall;
    logic        e_empty;
    logic        e_rwe;
    logic [31:0] e_waddr;
    logic [3:0]  e_wsel;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per byte lane, the youngest pending store that covers it wins.
  function automatic logic [31:0] m_read(input logic [31:0] ra, input logic [31:0] rd);
    logic [31:0] r;
    r = rd;
    for (int lane = 0; lane < 4; lane++) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].addr[31:2] == ra[31:2] && mq[i].sel[lane]) begin
          r[8*lane +: 8] = mq[i].data[8*lane +: 8];
          break;
        end
      end
    end
    return r;
  endfunction

  function automatic bit m_drain();
    return !reset && mq.size() > 0 && !cpu_read_enable;
  endfunction

  task automatic drive(input logic rst, input logic we, input logic [31:0] wa,
                       input logic [3:0] ws, input logic [31:0] wd, input logic re,
                       input logic [31:0] ra, input logic [31:0] rd);
    reset             = rst;
    cpu_write_enable  = we;
    cpu_write_address = wa;
    cpu_write_select  = ws;
    cpu_write_data    = wd;
    cpu_read_enable   = re;
    cpu_read_address  = ra;
    ram_read_data     = rd;
  endtask

  task automatic model_check();
    bit dr;
    dr = m_drain();
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("stall", 32'(stall_request),
        32'(cpu_write_enable && mq.size() == DEPTH && !dr));
    chk("ram_we", 32'(ram_write_enable), 32'(dr));
    if (dr) begin
      chk("ram_waddr", ram_write_address, mq[0].addr);
      chk("ram_wsel", 32'(ram_write_select), 32'(mq[0].sel));
      chk("ram_wdata", ram_write_data, mq[0].data);
    end
    if (cpu_read_enable) begin
      chk("rdata", cpu_read_data, m_read(cpu_read_address, ram_read_data));
    end
    chk("ram_re", 32'(ram_read_enable), 32'(cpu_read_enable));
    chk("ram_raddr", ram_read_address, cpu_read_address);
  endtask

  task automatic model_edge();
    bit dr, acc;
    if (reset) begin
      mq.delete();
    end else begin
      dr  = m_drain();
      acc = cpu_write_enable && (mq.size() < DEPTH || dr);
      if (dr) void'(mq.pop_front());
      if (acc) mq.push_back('{addr: {cpu_write_address[31:2], 2'b00},
                              sel: cpu_write_select, data: cpu_write_data});
    end
  endtask

  // Drive at the falling edge and check just after; the model advances at the rising edge.
  task automatic pre(input logic rst, input logic we, input logic [31:0] wa,
                     input logic [3:0] ws, input logic [31:0] wd, input logic re,
                     input logic [31:0] ra, input logic [31:0] rd);
    @(negedge clock);
    drive(rst, we, wa, ws, wd, re, ra, rd);
    #1;
    model_check();
  endtask

  task automatic post();
    @(posedge clock);
    model_edge();
  endtask

  task automatic step(input logic rst, input logic we, input logic [31:0] wa,
                      input logic [3:0] ws, input logic [31:0] wd, input logic re,
                      input logic [31:0] ra, input logic [31:0] rd);
    pre(rst, we, wa, ws, wd, re, ra, rd);
    post();
  endtask

  task automatic idle(input logic re);
    step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, re, 32'h0, 32'h0);
  endtask

  initial begin
    //        we  wa       ws     wd            re  ra       rd            stl emp rwe waddr    wsel   wdata         rdata
    tbl[0]  = '{0, 32'h0,   4'h0, 32'h0,        1, 32'h0,   32'h1234_5678, 0, 1, 0, 32'h0,   4'h0, 32'h0,        32'h1234_5678};
    tbl[1]  = '{1, 32'h100, 4'hF, 32'hDEAD_BEEF, 0, 32'h0,  32'h0,         0, 1, 0, 32'h0,   4'h0, 32'h0,        32'h0};
    tbl[2]  = '{0, 32'h0,   4'h0, 32'h0,        0, 32'h0,   32'h0,         0, 0, 1, 32'h100, 4'hF, 32'hDEAD_BEEF, 32'h0};
    tbl[3]  = '{0, 32'h0,   4'h0, 32'h0,        0, 32'h0,   32'h0,         0, 1, 0, 32'h0,   4'h0, 32'h0,        32'h0};
    tbl[4]  = '{1, 32'h200, 4'h3, 32'h0000_AAAA, 1, 32'h0,  32'h0,         0, 1, 0, 32'h0,   4'h0, 32'h0,        32'h0};
    tbl[5]  = '{1, 32'h200, 4'h2, 32'h0000_BB00, 1, 32'h200, 32'h1122_3344, 0, 0, 0, 32'h0,  4'h0, 32'h0,        32'h1122_AAAA};
    tbl[6]  = '{0, 32'h0,   4'h0, 32'h0,        1, 32'h200, 32'h1122_3344, 0, 0, 0, 32'h0,   4'h0, 32'h0,        32'h1122_BBAA};
    tbl[7]  = '{0, 32'h0,   4'h0, 32'h0,        1, 32'h204, 32'h5566_7788, 0, 0, 0, 32'h0,   4'h0, 32'h0,        32'h5566_7788};
    tbl[8]  = '{0, 32'h0,   4'h0, 32'h0,        0, 32'h0,   32'h0,         0, 0, 1, 32'h200, 4'h3, 32'h0000_AAAA, 32'h0};
    tbl[9]  = '{0, 32'h0,   4'h0, 32'h0,        0, 32'h0,   32'h0,         0, 0, 1, 32'h200, 4'h2, 32'h0000_BB00, 32'h0};
    tbl[10] = '{0, 32'h0,   4'h0, 32'h0,        0, 32'h0,   32'h0,         0, 1, 0, 32'h0,   4'h0, 32'h0,        32'h0};

    // Initial reset: DUT state is unknown until the first reset edge, so no checks here.
    drive(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clock);
    mq.delete();

    // Directed vector table (reset state, drain timing, forwarding merge).
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      drive(1'b0, tbl[i].we, tbl[i].wa, tbl[i].ws, tbl[i].wd, tbl[i].re, tbl[i].ra, tbl[i].rd);
      #1;
      chk($sformatf("tv%0d_stall", i), 32'(stall_request), 32'(tbl[i].e_stall));
      chk($sformatf("tv%0d_empty", i), 32'(empty), 32'(tbl[i].e_empty));
      chk($sformatf("tv%0d_ram_we", i), 32'(ram_write_enable), 32'(tbl[i].e_rwe));
      if (tbl[i].e_rwe) begin
        chk($sformatf("tv%0d_waddr", i), ram_write_address, tbl[i].e_waddr);
        chk($sformatf("tv%0d_wsel", i), 32'(ram_write_select), 32'(tbl[i].e_wsel));
        chk($sformatf("tv%0d_wdata", i), ram_write_data, tbl[i].e_wdata);
      end
      if (tbl[i].re) chk($sformatf("tv%0d_rdata", i), cpu_read_data, tbl[i].e_rdata);
      post();
    end

    // Full buffer: 5th store stalls, then drain and enqueue in the same cycle.
    step(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      pre(1'b0, 1'b1, 32'h300 + 32'(4 * k), 4'hF, 32'hA0 + 32'(k), 1'b1, 32'h500, 32'h0);
      chk($sformatf("full_stall%0d", k), 32'(stall_request), 32'(k == 4));
      post();
    end
    pre(1'b0, 1'b1, 32'h310, 4'hF, 32'hA4, 1'b0, 32'h0, 32'h0);
    chk("full_release_stall", 32'(stall_request), 32'h0);
    chk("full_release_we", 32'(ram_write_enable), 32'h1);
    chk("full_release_addr", ram_write_address, 32'h300);
    post();
    for (int j = 1; j < 5; j++) begin
      pre(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0);
      chk($sformatf("full_order%0d", j), ram_write_address, 32'h300 + 32'(4 * j));
      chk($sformatf("full_data%0d", j), ram_write_data, 32'hA0 + 32'(j));
      post();
    end
    pre(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("full_empty_after", 32'(empty), 32'h1);
    post();

    // Pointer wrap: advance head to 3, then fill 3 across the wrap and drain.
    step(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 32'h600 + 32'(4 * k), 4'hF, 32'(k), 1'b1, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) idle(1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 32'h700 + 32'(4 * k), 4'hF, 32'hC0 + 32'(k), 1'b1, 32'h0, 32'h0);
    pre(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h704, 32'hFFFF_FFFF);
    chk("wrap_fwd", cpu_read_data, 32'hC1);
    post();
    for (int k = 0; k < 3; k++) begin
      pre(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0);
      chk($sformatf("wrap_order%0d", k), ram_write_address, 32'h700 + 32'(4 * k));
      post();
    end
    pre(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("wrap_empty", 32'(empty), 32'h1);
    post();

    // Reset with stores pending: write enable drops in the reset cycle itself.
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 32'h800 + 32'(4 * k), 4'hF, 32'(k), 1'b1, 32'h0, 32'h0);
    pre(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("rst_we_same_cycle", 32'(ram_write_enable), 32'h0);
    post();
    for (int k = 0; k < 2; k++) begin
      pre(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0);
      chk($sformatf("rst_empty%0d", k), 32'(empty), 32'h1);
      chk($sformatf("rst_no_write%0d", k), 32'(ram_write_enable), 32'h0);
      post();
    end

    // Randomized traffic on a small address pool to exercise forwarding and full/drain races.
    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
           32'h400 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3)),
           4'($urandom), $urandom, ($urandom_range(0, 99) < 55),
           32'h400 + 32'(4 * $urandom_range(0, 3)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
